// File: rtl/display_pkg.sv
// Shared constants for the writeback display controller: source selects,
// digit count and the active-low seven-segment glyph table.
package display_pkg;

  localparam logic [1:0] SEL_WRDATA = 2'd0;
  localparam logic [1:0] SEL_PC     = 2'd1;
  localparam logic [1:0] SEL_V0     = 2'd2;
  localparam logic [1:0] SEL_V1     = 2'd3;

  localparam int NUM_DIGITS = 8;

  // Glyphs as {g,f,e,d,c,b,a}, a segment is lit when its bit is 0.
  localparam logic [15:0][6:0] HEX7_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment glyph.
module hex_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = HEX7_TABLE[i_nibble];

endmodule

// File: rtl/wb_display_ctrl.sv
// Frame-synchronous snapshot of a selected pipeline word, scanned as eight
// hex digits onto a common-anode active-low display.
module wb_display_ctrl
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] WriteData,
  input  logic [31:0] WB_PCAddResult,
  input  logic [31:0] v0,
  input  logic [31:0] v1,
  input  logic [1:0]  Sel,
  input  logic        Hold,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [31:0] DispValue
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_dig;
  logic [31:0]      r_disp;
  logic [7:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;

  logic        w_tick;
  logic        w_reload;
  logic [31:0] w_src;
  logic [3:0]  w_nibble;
  logic [6:0]  w_glyph;

  assign w_tick   = (r_cnt == CNT_MAX);
  // The reload edge is also the 7->0 digit wrap, so digit 0 is always fresh.
  assign w_reload = w_tick && (r_dig == 3'(NUM_DIGITS - 1)) && !Hold;

  always_comb begin
    w_src = WriteData;
    case (Sel)
      SEL_WRDATA: w_src = WriteData;
      SEL_PC:     w_src = WB_PCAddResult;
      SEL_V0:     w_src = v0;
      SEL_V1:     w_src = v1;
      default:    w_src = WriteData;
    endcase
  end

  assign w_nibble = r_disp[{r_dig, 2'b00} +: 4];

  hex_to_7seg u_hex (
    .i_nibble (w_nibble),
    .o_seg    (w_glyph)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cnt <= '0;
      r_dig <= '0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
      if (w_tick) r_dig <= r_dig + 3'd1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_disp <= '0;
    end else if (w_reload) begin
      r_disp <= w_src;
    end
  end

  // Display drive lags the digit counter and snapshot by one edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_an  <= 8'hFF;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= ~(8'b1 << r_dig);
      r_seg <= w_glyph;
      r_dp  <= !(Hold && (r_dig == 3'd0));
    end
  end

  assign an        = r_an;
  assign seg       = r_seg;
  assign dp        = r_dp;
  assign DispValue = r_disp;

endmodule
